ex_mem_skid_buffer: RTL

EX_MEM_SKID_BUFFER -- requirements
Module: ex_mem_skid_buffer

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/ex_mem_entry.sv | 25 ++
 rtl/ex_mem_skid_buffer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared datapath widths, payload layout width and EX/MEM buffer state encoding.
package riscv_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int CTRL_W     = 4;  // zero, reg_write, mem_read, mem_write

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

    function automatic int payload_w(input int data_w, input int reg_addr_w);
        return 2 * data_w + reg_addr_w + CTRL_W;
    endfunction

    localparam int PAYLOAD_W = payload_w(DATA_W, REG_ADDR_W);

endpackage

// File: rtl/ex_mem_entry.sv
// One payload slot of the EX/MEM skid buffer: load-enabled register with async clear.
module ex_mem_entry #(
    parameter int W = riscv_pkg::PAYLOAD_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_q;

    // NOTE: payload is cleared on reset so out_* and the skid slot start at a known zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/ex_mem_skid_buffer.sv
// Two-entry EX/MEM pipeline skid buffer: registered ready/valid, FIFO order, flush.
module ex_mem_skid_buffer #(
    parameter int DATA_W     = riscv_pkg::DATA_W,
    parameter int REG_ADDR_W = riscv_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_result,
    input  logic                  in_zero,
    input  logic [DATA_W-1:0]     in_store_data,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_reg_write,
    input  logic                  in_mem_read,
    input  logic                  in_mem_write,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_result,
    output logic                  out_zero,
    output logic [DATA_W-1:0]     out_store_data,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_reg_write,
    output logic                  out_mem_read,
    output logic                  out_mem_write
);

    import riscv_pkg::*;

    localparam int PW = payload_w(DATA_W, REG_ADDR_W);

    skid_state_e state_q, state_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic        in_fire, out_fire;
    logic        head_load, skid_load, head_from_skid;
    logic [PW-1:0] in_payload, head_d, head_q, skid_q;

    assign in_fire  = in_valid && in_ready_q;
    assign out_fire = out_valid_q && out_ready;

    // Writes to x0 are architecturally void, so drop reg_write at capture.
    assign in_payload = {in_result, in_zero, in_store_data, in_rd,
                         in_reg_write && (in_rd != '0), in_mem_read, in_mem_write};

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d        = state_q;
        head_load      = 1'b0;
        skid_load      = 1'b0;
        head_from_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d   = ONE;
                    head_load = 1'b1;
                end
            end
            ONE: begin
                case ({in_fire, out_fire})
                    2'b10: begin
                        state_d   = TWO;
                        skid_load = 1'b1;
                    end
                    2'b01:   state_d   = EMPTY;
                    2'b11:   head_load = 1'b1;
                    default: ;
                endcase
            end
            TWO: begin
                if (out_fire) begin
                    state_d        = ONE;
                    head_load      = 1'b1;
                    head_from_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
        end
        in_ready_d  = (state_d != TWO);
        out_valid_d = (state_d != EMPTY);
    end

    assign head_d = head_from_skid ? skid_q : in_payload;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    ex_mem_entry #(.W(PW)) u_head (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (head_load),
        .d     (head_d),
        .q     (head_q)
    );

    ex_mem_entry #(.W(PW)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (skid_load),
        .d     (in_payload),
        .q     (skid_q)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign {out_result, out_zero, out_store_data, out_rd,
            out_reg_write, out_mem_read, out_mem_write} = head_q;

endmodule
